// File: rtl/nem_ohmux_seq.sv
// One-hot relay multiplexer sequencer.
// Drives a bank of NI relays so that at most one path is closed at a time.
// Switching between two inputs opens every relay for T_BRK cycles (break),
// then closes the new one and waits T_MAKE cycles for pull-in (make) before
// flagging the output valid. ZN is the inverted OR of the selected words,
// registered from the registered select drive.
//
// Handshake: a request (REQ_VLD plus REQ_OFF/REQ_SEL) is taken on a rising
// edge where REQ_VLD and REQ_RDY are both 1. REQ_RDY is high only while the
// sequencer is idle (OPEN) or settled (ON). Requests shown while REQ_RDY is
// low are dropped, not queued. REQ_OFF has priority over REQ_SEL. An accepted
// index that does not name an input raises ERR for one cycle and changes
// nothing else.
//
// REQ_SEL is one bit wider than an index needs, so that an out-of-range
// index can actually be presented and reported.
module nem_ohmux_seq #(
  parameter int NI     = 4,
  parameter int W      = 8,
  parameter int T_BRK  = 2,
  parameter int T_MAKE = 3,
  localparam int SW    = $clog2(NI + 1)
) (
  input  logic              CP,
  input  logic              CD,
  input  logic [NI*W-1:0]   I,
  input  logic              REQ_VLD,
  input  logic [SW-1:0]     REQ_SEL,
  input  logic              REQ_OFF,
  output logic              REQ_RDY,
  output logic [NI-1:0]     S,
  output logic [W-1:0]      ZN,
  output logic              VLD,
  output logic              ERR,
  output logic [1:0]        fsm_state
);

  localparam int IW   = (NI > 1) ? $clog2(NI) : 1;
  localparam int TMAX = (T_BRK > T_MAKE) ? T_BRK : T_MAKE;
  localparam int CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_OPEN  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_ON    = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [NI-1:0]   s_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   tgt, tgt_nx;
  logic            err_nx;
  logic            accept;
  logic            illegal;
  logic [W-1:0]    sel_word;

  assign REQ_RDY   = (state == ST_OPEN) || (state == ST_ON);
  assign VLD       = (state == ST_ON);
  assign fsm_state = state;
  assign accept    = REQ_VLD && REQ_RDY;
  assign illegal   = (REQ_SEL >= SW'(NI));

  function automatic logic [NI-1:0] onehot(input logic [IW-1:0] idx);
    onehot = NI'(1) << idx;
  endfunction

  // Next-state, next select drive, counter and error pulse.
  always_comb begin
    state_nx = state;
    s_nx     = S;
    cnt_nx   = cnt;
    tgt_nx   = tgt;
    err_nx   = 1'b0;
    case (state)
      ST_OPEN: begin
        if (accept) begin
          if (REQ_OFF) begin
            s_nx = '0;
          end else if (illegal) begin
            err_nx = 1'b1;
          end else begin
            tgt_nx   = IW'(REQ_SEL);
            s_nx     = onehot(IW'(REQ_SEL));
            cnt_nx   = CW'(T_MAKE - 1);
            state_nx = ST_MAKE;
          end
        end
      end
      ST_ON: begin
        if (accept) begin
          if (REQ_OFF) begin
            s_nx     = '0;
            cnt_nx   = '0;
            state_nx = ST_OPEN;
          end else if (illegal) begin
            err_nx = 1'b1;
          end else if (REQ_SEL != SW'(tgt)) begin
            tgt_nx   = IW'(REQ_SEL);
            s_nx     = '0;
            cnt_nx   = CW'(T_BRK - 1);
            state_nx = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (cnt == '0) begin
          s_nx     = onehot(tgt);
          cnt_nx   = CW'(T_MAKE - 1);
          state_nx = ST_MAKE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_MAKE: begin
        if (cnt == '0) begin
          state_nx = ST_ON;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        s_nx     = '0;
        cnt_nx   = '0;
        state_nx = ST_OPEN;
      end
    endcase
  end

  // State, select drive, counter, latched target and error pulse registers.
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state <= ST_OPEN;
      S     <= '0;
      cnt   <= '0;
      tgt   <= '0;
      ERR   <= 1'b0;
    end else begin
      state <= state_nx;
      S     <= s_nx;
      cnt   <= cnt_nx;
      tgt   <= tgt_nx;
      ERR   <= err_nx;
    end
  end

  // OR of the words whose relay is currently driven.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NI; k++) begin
      if (S[k]) sel_word = sel_word | I[k*W +: W];
    end
  end

  // Inverted selection, one cycle behind the select drive.
  always_ff @(posedge CP or posedge CD) begin
    if (CD) ZN <= '1;
    else    ZN <= ~sel_word;
  end

endmodule

// File: tb/tb_nem_ohmux_seq.sv
// Bench for nem_ohmux_seq: directed scenarios followed by random requests,
// compared every cycle against a timestamp-based model of the relay sequence.
module tb_nem_ohmux_seq;

  localparam int NI     = 4;
  localparam int W      = 8;
  localparam int T_BRK  = 2;
  localparam int T_MAKE = 3;
  localparam int SW     = $clog2(NI + 1);

  logic            CP = 1'b0;
  logic            CD = 1'b1;
  logic [NI*W-1:0] I = '0;
  logic            REQ_VLD = 1'b0;
  logic [SW-1:0]   REQ_SEL = '0;
  logic            REQ_OFF = 1'b0;
  logic            REQ_RDY;
  logic [NI-1:0]   S;
  logic [W-1:0]    ZN;
  logic            VLD;
  logic            ERR;
  logic [1:0]      fsm_state;

  nem_ohmux_seq #(.NI(NI), .W(W), .T_BRK(T_BRK), .T_MAKE(T_MAKE)) dut (
    .CP(CP), .CD(CD), .I(I), .REQ_VLD(REQ_VLD), .REQ_SEL(REQ_SEL),
    .REQ_OFF(REQ_OFF), .REQ_RDY(REQ_RDY), .S(S), .ZN(ZN), .VLD(VLD),
    .ERR(ERR), .fsm_state(fsm_state)
  );

  // Clock
  always #5 CP = ~CP;

  int n_vec = 0;
  int n_err = 0;

  // Model: which input is (or is becoming) connected, the edge at which its
  // relay closes and the edge from which the path counts as made.
  int            e      = 0;
  int            sel_m  = -1;
  int            make_at = 0;
  int            on_at   = 0;
  logic [NI-1:0] m_s;
  logic          m_vld, m_rdy, m_err;
  logic [W-1:0]  m_zn;

  logic [NI*W-1:0] data_a = {8'hC3, 8'h0F, 8'h5A, 8'h33};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_or(input logic [NI-1:0] s, input logic [NI*W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NI; k++) if (s[k]) r |= d[k*W +: W];
    return r;
  endfunction

  task automatic model_reset();
    sel_m = -1;
    m_s   = '0;
    m_vld = 1'b0;
    m_rdy = 1'b1;
    m_err = 1'b0;
    m_zn  = '1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":S"},   32'(S),       32'(m_s));
    chk({tag, ":VLD"}, 32'(VLD),     32'(m_vld));
    chk({tag, ":RDY"}, 32'(REQ_RDY), 32'(m_rdy));
    chk({tag, ":ERR"}, 32'(ERR),     32'(m_err));
    chk({tag, ":ZN"},  32'(ZN),      32'(m_zn));
    chk({tag, ":ONEHOT"}, 32'($countones(S) <= 1), 32'(1));
  endtask

  // One clock: drive request and data, advance the model, sample after the edge.
  task automatic step(input logic v, input logic off, input int sel, input logic [NI*W-1:0] d);
    REQ_VLD = v;
    REQ_OFF = off;
    REQ_SEL = SW'(sel);
    I       = d;
    e++;
    m_zn  = ~word_or(m_s, d);
    m_err = 1'b0;
    if (v && m_rdy) begin
      if (off) begin
        sel_m = -1;
      end else if (sel >= NI) begin
        m_err = 1'b1;
      end else if (sel_m < 0) begin
        sel_m = sel; make_at = e; on_at = e + T_MAKE;
      end else if (sel != sel_m) begin
        sel_m = sel; make_at = e + T_BRK; on_at = e + T_BRK + T_MAKE;
      end
    end
    if (sel_m < 0) begin
      m_s = '0; m_vld = 1'b0; m_rdy = 1'b1;
    end else begin
      m_s   = (e >= make_at) ? (NI'(1) << sel_m) : '0;
      m_vld = (e >= on_at);
      m_rdy = (e >= on_at);
    end
    @(posedge CP);
    #1;
    check_all("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, data_a);
  endtask

  initial begin
    model_reset();
    // Reset held over two edges, released just after an edge.
    @(posedge CP); #1;
    @(posedge CP); #1;
    check_all("reset");
    CD = 1'b0;

    // Accept sel=2 from OPEN on the first edge after release.
    step(1'b1, 1'b0, 2, data_a);
    chk("sel2_accept_S", 32'(S), 32'h4);
    step(1'b0, 1'b0, 0, data_a);
    chk("sel2_zn", 32'(ZN), 32'hF0);
    idle(1);
    chk("sel2_make_vld", 32'(VLD), 32'h0);
    idle(1);
    chk("sel2_on_vld", 32'(VLD), 32'h1);

    // Switch to sel=1: break then make; REQ_SEL wiggles during break.
    step(1'b1, 1'b0, 1, data_a);
    chk("brk_S0", 32'(S), 32'h0);
    step(1'b1, 1'b0, 3, data_a);
    chk("brk_S1", 32'(S), 32'h0);
    step(1'b0, 1'b0, 0, data_a);
    chk("make_S", 32'(S), 32'h2);
    idle(3);
    chk("sel1_on_vld", 32'(VLD), 32'h1);

    // Same index again: no change.
    step(1'b1, 1'b0, 1, data_a);
    chk("same_rdy", 32'(REQ_RDY), 32'h1);

    // Off from ON, then ZN all ones a cycle later.
    step(1'b1, 1'b1, 2, data_a);
    chk("off_vld", 32'(VLD), 32'h0);
    step(1'b0, 1'b0, 0, data_a);
    chk("off_zn", 32'(ZN), 32'hFF);

    // Out-of-range index in OPEN: one-cycle ERR.
    step(1'b1, 1'b0, 5, data_a);
    chk("err_pulse", 32'(ERR), 32'h1);
    step(1'b0, 1'b0, 0, data_a);
    chk("err_clear", 32'(ERR), 32'h0);

    // Reset during MAKE acts without a clock edge and drops the request.
    step(1'b1, 1'b0, 3, data_a);
    idle(1);
    #2;
    CD = 1'b1;
    #1;
    model_reset();
    chk("async_S", 32'(S), 32'h0);
    chk("async_VLD", 32'(VLD), 32'h0);
    chk("async_RDY", 32'(REQ_RDY), 32'h1);
    chk("async_ZN", 32'(ZN), 32'hFF);
    @(posedge CP); #1;
    CD = 1'b0;
    idle(T_MAKE + 1);
    chk("no_resume_S", 32'(S), 32'h0);
    step(1'b1, 1'b0, 0, data_a);
    chk("first_after_rst", 32'(S), 32'h1);

    // Random requests and data.
    for (int i = 0; i < 600; i++) begin
      logic v, off;
      v   = ($urandom_range(0, 2) == 0);
      off = ($urandom_range(0, 7) == 0);
      step(v, off, int'($urandom_range(0, 5)), {$urandom, $urandom} );
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
